// File: rtl/fuc_pkg.sv
// ---------------------------------------------------------------------------
// fuc_pkg -- shared definitions for frame_update_controller.
//   * fuc_state_e : controller FSM state (IDLE, PENDING, COMMIT)
//   * LOC_W       : rover (r,theta) location word width
//   * ORIENT_W    : rover orientation word width
//   * ovr_inc     : number of overruns (0..2) seen on one edge
// ---------------------------------------------------------------------------
package fuc_pkg;

    localparam int LOC_W    = 12;
    localparam int ORIENT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } fuc_state_e;

    // Both channels can overrun on the same edge, so the step is 0, 1 or 2.
    function automatic logic [1:0] ovr_inc(input logic loc_ovr, input logic orient_ovr);
        return {1'b0, loc_ovr} + {1'b0, orient_ovr};
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen -- turns the active-low XVGA vsync into a one-cycle
// frame_tick at the start of vertical sync.
// Ports:
//   vclock     : pixel clock
//   reset_n    : asynchronous active-low reset
//   vsync      : vertical sync, active low, vclock domain
//   frame_tick : high in the cycle where vsync is low and its copy is high
// ---------------------------------------------------------------------------
module frame_tick_gen (
    input  logic vclock,
    input  logic reset_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_r;

    // Registered copy of vsync; resets high so no tick is faked out of reset.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_r <= 1'b1;
        end else begin
            vsync_r <= vsync;
        end
    end

    // Falling-edge detect; combinational so a transfer on the tick cycle
    // still lands in that frame's commit.
    assign frame_tick = ~vsync & vsync_r;

endmodule

// File: rtl/frame_update_controller.sv
// ---------------------------------------------------------------------------
// frame_update_controller -- buffers rover location/orientation updates and
// publishes them to the display only at the start of vertical sync, so the
// displayed values never change mid-frame.
// Optional feature: define FRAME_UPDATE_OVERRUN_CNT_EN to add overrun_count.
// Ports:
//   vclock, reset_n               : pixel clock, async active-low reset
//   vsync                         : XVGA vertical sync (active low)
//   loc_valid/loc_data/loc_ready  : location handshake
//   orient_valid/orient_data/orient_ready : orientation handshake
//   disp_location, disp_orientation : values held stable for the display
//   disp_new_data                 : a location was committed this frame
//   disp_orientation_ready        : orientation is fresh (not stale)
//   overrun_count                 : saturating overwrite count (optional)
// ---------------------------------------------------------------------------
module frame_update_controller
    import fuc_pkg::*;
#(
    parameter int STALE_FRAMES = 60,
    parameter int OVR_W        = 8
) (
    input  logic                vclock,
    input  logic                reset_n,
    input  logic                vsync,
    input  logic                loc_valid,
    input  logic [LOC_W-1:0]    loc_data,
    output logic                loc_ready,
    input  logic                orient_valid,
    input  logic [ORIENT_W-1:0] orient_data,
    output logic                orient_ready,
    output logic [LOC_W-1:0]    disp_location,
    output logic [ORIENT_W-1:0] disp_orientation,
    output logic                disp_new_data,
    output logic                disp_orientation_ready
`ifdef FRAME_UPDATE_OVERRUN_CNT_EN
    ,
    output logic [OVR_W-1:0]    overrun_count
`endif
);

    // A zero-frame timeout still needs a 1-bit counter to exist.
    localparam int SW = (STALE_FRAMES > 0) ? $clog2(STALE_FRAMES + 1) : 1;

    fuc_state_e          state_r;
    fuc_state_e          state_nxt_s;
    logic                ready_r;
    logic                frame_tick_s;
    logic                loc_xfer_s;
    logic                orient_xfer_s;
    logic                loc_pend_r;
    logic                orient_pend_r;
    logic [LOC_W-1:0]    loc_buf_r;
    logic [ORIENT_W-1:0] orient_buf_r;
    logic [LOC_W-1:0]    disp_location_r;
    logic [ORIENT_W-1:0] disp_orientation_r;
    logic                disp_new_data_r;
    logic                disp_orientation_ready_r;
    logic [SW-1:0]       stale_cnt_r;

    frame_tick_gen u_frame_tick_gen (
        .vclock     (vclock),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .frame_tick (frame_tick_s)
    );

    assign loc_xfer_s    = loc_valid & ready_r;
    assign orient_xfer_s = orient_valid & ready_r;

    // Next-state logic; a transfer on the tick cycle skips PENDING.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_tick_s && (loc_xfer_s || orient_xfer_s)) begin
                    state_nxt_s = COMMIT;
                end else if (loc_xfer_s || orient_xfer_s) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PENDING: begin
                if (frame_tick_s) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = PENDING;
                end
            end
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered ready (low only while in COMMIT).
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != COMMIT);
        end
    end

    // One-entry pending buffers; latest transfer wins, commit clears the flags.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            loc_pend_r    <= 1'b0;
            orient_pend_r <= 1'b0;
            loc_buf_r     <= '0;
            orient_buf_r  <= '0;
        end else if (state_r == COMMIT) begin
            loc_pend_r    <= 1'b0;
            orient_pend_r <= 1'b0;
        end else begin
            if (loc_xfer_s) begin
                loc_buf_r  <= loc_data;
                loc_pend_r <= 1'b1;
            end
            if (orient_xfer_s) begin
                orient_buf_r  <= orient_data;
                orient_pend_r <= 1'b1;
            end
        end
    end

    // Display registers only move on the COMMIT->IDLE edge.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            disp_location_r    <= '0;
            disp_orientation_r <= '0;
        end else if (state_r == COMMIT) begin
            if (loc_pend_r) begin
                disp_location_r <= loc_buf_r;
            end
            if (orient_pend_r) begin
                disp_orientation_r <= orient_buf_r;
            end
        end
    end

    // New-data flag: set by a location commit, dropped at a tick carrying no
    // location. A tick that will commit location leaves it alone so it does
    // not glitch low for one cycle.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            disp_new_data_r <= 1'b0;
        end else if ((state_r == COMMIT) && loc_pend_r) begin
            disp_new_data_r <= 1'b1;
        end else if (frame_tick_s && !loc_pend_r && !loc_xfer_s) begin
            disp_new_data_r <= 1'b0;
        end
    end

    // Orientation staleness: reload on orientation commit, count down on
    // ticks without one, drop ready as the count hits zero and hold there.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            stale_cnt_r              <= '0;
            disp_orientation_ready_r <= 1'b0;
        end else if ((state_r == COMMIT) && orient_pend_r) begin
            stale_cnt_r              <= SW'(STALE_FRAMES);
            disp_orientation_ready_r <= 1'b1;
        end else if (frame_tick_s && !orient_pend_r && !orient_xfer_s &&
                     (stale_cnt_r != '0)) begin
            stale_cnt_r <= stale_cnt_r - SW'(1);
            if (stale_cnt_r == SW'(1)) begin
                disp_orientation_ready_r <= 1'b0;
            end
        end
    end

`ifdef FRAME_UPDATE_OVERRUN_CNT_EN
    logic [OVR_W-1:0] overrun_cnt_r;
    logic [OVR_W:0]   overrun_sum_s;

    assign overrun_sum_s = {1'b0, overrun_cnt_r} +
                           {{(OVR_W-1){1'b0}}, ovr_inc(loc_xfer_s & loc_pend_r,
                                                       orient_xfer_s & orient_pend_r)};

    // Saturating overrun counter; the carry bit flags wrap-around.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt_r <= '0;
        end else if (overrun_sum_s[OVR_W]) begin
            overrun_cnt_r <= '1;
        end else begin
            overrun_cnt_r <= overrun_sum_s[OVR_W-1:0];
        end
    end

    assign overrun_count = overrun_cnt_r;
`endif

    assign loc_ready              = ready_r;
    assign orient_ready           = ready_r;
    assign disp_location          = disp_location_r;
    assign disp_orientation       = disp_orientation_r;
    assign disp_new_data          = disp_new_data_r;
    assign disp_orientation_ready = disp_orientation_ready_r;

endmodule

// File: doc/frame_update_controller.md
FRAME_UPDATE_CONTROLLER -- requirements
Module: frame_update_controller

Interface
REQ-001: The block SHALL have parameter STALE_FRAMES, default 60, giving the number of frame ticks without a new orientation before disp_orientation_ready drops.
REQ-002: The block SHALL have parameter OVR_W, default 8, giving the overrun counter width.
REQ-003: The block SHALL have port vclock, input, 1 bit: the 65MHz pixel clock and the only clock.
REQ-004: The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005: The block SHALL have port vsync, input, 1 bit: XVGA vertical sync, active low, generated in the vclock domain.
REQ-006: The block SHALL have ports loc_valid in 1, loc_data in 12 and loc_ready out 1: the rover (r,theta) location handshake.
REQ-007: The block SHALL have ports orient_valid in 1, orient_data in 4 and orient_ready out 1: the rover orientation handshake.
REQ-008: The block SHALL have ports disp_location out 12 and disp_orientation out 4: values held stable for the display.
REQ-009: The block SHALL have ports disp_new_data out 1 and disp_orientation_ready out 1: display qualifiers, level signals.
REQ-010: The block SHALL have port overrun_count, out, OVR_W bits, present only when the Configuration macro is defined.

Function
REQ-011: frame_tick SHALL be a one-cycle strobe asserted in the cycle where vsync is sampled low and its registered copy is high.
REQ-012: A transfer SHALL occur on any edge where valid and ready are both high.
- Each channel has a one-entry pending buffer plus a pending flag.
REQ-013: A transfer into a full pending buffer SHALL overwrite it (latest wins) and count as an overrun.
REQ-014: The FSM SHALL have three states, IDLE, PENDING and COMMIT, with these transitions:
- IDLE->PENDING on any transfer.
- PENDING->COMMIT on frame_tick.
- IDLE->IDLE on frame_tick.
- COMMIT->IDLE unconditionally after one cycle.
REQ-015: loc_ready and orient_ready SHALL be 1 in IDLE and PENDING and 0 in COMMIT.
REQ-016: A transfer in the same cycle as frame_tick SHALL be captured and included in that commit; from IDLE, the FSM goes directly to COMMIT.
REQ-017: In COMMIT, each channel with its pending flag set SHALL load its disp_* register on the COMMIT->IDLE edge and clear its flag.
- Latency: disp_* are updated 2 vclock edges after the frame_tick edge.
REQ-018: disp_new_data SHALL be set at a commit that includes location, and cleared at the next frame_tick whose commit includes no location.
- It therefore stays high for at least one full frame, covering the posedge-vsync sampling point.
REQ-019: disp_orientation_ready SHALL be set at a commit that includes orientation.
- A stale counter reloads to STALE_FRAMES on that commit and decrements on each frame_tick without an orientation commit.
- On reaching 0, the counter clears disp_orientation_ready and holds at 0.
REQ-020: disp_location and disp_orientation SHALL never change except on the COMMIT->IDLE edge or on reset.
REQ-021: The stale counter width SHALL be clog2(STALE_FRAMES+1).
- STALE_FRAMES=0 means disp_orientation_ready stays high until reset.

Reset
REQ-022: Asserting reset_n low SHALL asynchronously force the following, including mid-COMMIT:
- FSM to IDLE and pending flags to 0.
- disp_location=0, disp_orientation=0, disp_new_data=0, disp_orientation_ready=0.
- Stale counter to 0, overrun_count to 0, and the registered vsync copy to 1.
REQ-023: Pending data present at reset SHALL be discarded; loc_ready and orient_ready SHALL be 1 on the first edge after reset_n deasserts.

Configuration
REQ-024: With macro FRAME_UPDATE_OVERRUN_CNT_EN defined, overrun_count SHALL be present.
- It increments once per overrun edge, on either channel, and saturates at all-ones.
- If both channels overrun on the same edge, it increments by 2, still saturating.
REQ-025: Without FRAME_UPDATE_OVERRUN_CNT_EN, the overrun_count port and counter logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026: Shared package fuc_pkg SHALL hold:
- The FSM state enum (IDLE, PENDING, COMMIT).
- LOC_W=12 and ORIENT_W=4.
REQ-027: Sub-module frame_tick_gen SHALL contain the vsync register and the edge detect, and output frame_tick.

Verification
REQ-028: Reset, then loc transfer 12'hA35 mid-frame, then a vsync fall -> disp_location=12'hA35 and disp_new_data=1, 2 edges after frame_tick; ready is 0 for exactly one cycle.
REQ-029: Location transfers 12'h001, 12'h002 and 12'h003 within one frame -> next commit shows 12'h003; overrun_count=2 with the macro defined.
REQ-030: Orientation 4'h5 committed, STALE_FRAMES=3, then no further orientations -> disp_orientation_ready falls on the 3rd following frame_tick; disp_orientation stays 4'h5.
REQ-031: loc_valid with data 12'h0FF asserted on the frame_tick cycle, FSM in IDLE -> same-frame commit of 12'h0FF.
REQ-032: reset_n pulsed low during COMMIT with location pending -> all outputs 0 immediately, no commit on the next frame_tick, disp_new_data stays 0.
REQ-033: Location only, then a frame with no data -> disp_new_data is high for one frame, then 0 after the second frame_tick.
